// File: rtl/fifo_result_checker.sv
// fifo_result_checker
// Tail-of-datapath self-check. Pops num_words result words from the output FIFO
// of the add-OFFSET stage and compares word i against seed + OFFSET + i
// (mod 2^DATA_W). It reports progress, the error count, the first mismatch,
// an empty-FIFO timeout and an overall pass flag.
//
// Ports:
//   clock, reset_n     rising-edge clock, async active-low reset
//   empty, din, rd     FIFO read side (din is valid the cycle after rd)
//   start              one-cycle pulse, accepted only in IDLE or DONE
//   num_words, seed    run length and sequence base, sampled on accepted start
//   busy               high in RUN and DRAIN
//   done, pass         run finished / finished cleanly
//   timeout            run aborted because the FIFO stayed empty too long
//   word_count         words compared so far
//   err_count          mismatches so far (saturating)
//   first_err_index    index of the first mismatch
//   first_err_data     din value at the first mismatch
module fifo_result_checker #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned OFFSET         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              empty,
    input  logic [DATA_W-1:0] din,
    output logic              rd,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_index,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  num_words_q;
    logic [DATA_W-1:0] seed_q;
    logic [CNT_W-1:0]  issued;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rd_d1;

    logic [DATA_W-1:0] exp_data;
    logic              mismatch;
    logic              start_ok;
    logic              last_issue;
    logic              tmo_hit;

    // Pop whenever the FIFO has data and words remain to be requested.
    assign rd = (state == S_RUN) && !empty && (issued < num_words_q);

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign pass = done && (err_count == '0) && !timeout;

    // Expected word wraps naturally at DATA_W bits.
    assign exp_data   = seed_q + DATA_W'(OFFSET) + DATA_W'(word_count);
    assign mismatch   = rd_d1 && (din != exp_data);
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_issue = rd && (issued == (num_words_q - CNT_ONE));
    // TIMEOUT_CYCLES consecutive RUN cycles without a pop.
    assign tmo_hit    = (state == S_RUN) && !rd && (tmo_cnt == TMO_LAST);

    // State, counters and registered status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            num_words_q     <= '0;
            seed_q          <= '0;
            issued          <= '0;
            tmo_cnt         <= '0;
            rd_d1           <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            word_count      <= '0;
            err_count       <= '0;
            first_err_index <= '0;
            first_err_data  <= '0;
        end else begin
            rd_d1 <= rd;

            // Compare stage: din belongs to the pop issued last cycle.
            if (rd_d1) begin
                word_count <= word_count + CNT_ONE;
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_ONE;
                    end
                    if (err_count == '0) begin
                        first_err_index <= word_count;
                        first_err_data  <= din;
                    end
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        num_words_q     <= num_words;
                        seed_q          <= seed;
                        issued          <= '0;
                        tmo_cnt         <= '0;
                        timeout         <= 1'b0;
                        word_count      <= '0;
                        err_count       <= '0;
                        first_err_index <= '0;
                        first_err_data  <= '0;
                        if (num_words == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (rd) begin
                        issued  <= issued + CNT_ONE;
                        tmo_cnt <= '0;
                        if (last_issue) begin
                            state <= S_DRAIN;
                        end
                    end else if (tmo_hit) begin
                        timeout <= 1'b1;
                        // A pop still in flight gets its compare before DONE.
                        if (rd_d1) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                S_DRAIN: begin
                    // Final compare lands on this edge.
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_result_checker.md
Name: fifo_result_checker

Overview:
- Downstream consumer of the add-2 processing stage's output FIFO.
- Pops N result words, compares each against an expected incrementing sequence (seed + OFFSET + index), and reports word count, error count, first-mismatch details, timeout and pass/fail.
- Used as the on-chip self-check at the tail of the FIFO test datapath; software programs seed/length, pulses start, then polls status.

Parameters:
- DATA_W, 32, data width of FIFO words and seed.
- CNT_W, 16, width of length and counters.
- OFFSET, 2, constant the upstream stage adds to each word.
- TIMEOUT_CYCLES, 1024, consecutive RUN cycles with FIFO empty before the run is aborted.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- empty  in  1  output-FIFO empty flag.
- din  in  DATA_W  FIFO read data, valid the cycle after rd.
- rd  out  1  FIFO pop strobe.
- start  in  1  one-cycle pulse that begins a run.
- num_words  in  CNT_W  words to check; sampled on accepted start.
- seed  in  DATA_W  sequence base; sampled on accepted start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE until next accepted start.
- pass  out  1  done && err_count==0 && !timeout.
- timeout  out  1  run aborted by empty timeout.
- word_count  out  CNT_W  words compared so far.
- err_count  out  CNT_W  mismatches so far; saturates at all-ones.
- first_err_index  out  CNT_W  index of first mismatch.
- first_err_data  out  DATA_W  din value at first mismatch.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs and counters 0; rd=0.
- States: IDLE, RUN, DRAIN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE and is ignored while busy.
  - On acceptance: latch num_words and seed; clear word_count, err_count, first_err_*, timeout and issued count; done=0.
  - Next state is RUN, or DONE directly if num_words==0 (pass=1 the following cycle).
- Read issue:
  - rd = (state==RUN) && !empty && (issued < num_words_q).
  - rd is combinational from registered state/counters and the empty input, so one pop per cycle is possible and a pop is never issued while empty.
  - issued increments on each rd.
- Compare pipeline:
  - rd_d1 = rd delayed one cycle. On rd_d1, compare din against exp = seed_q + OFFSET + word_count (mod 2^DATA_W), then increment word_count.
  - On mismatch: increment err_count (saturating). If err_count was 0, capture first_err_index=word_count and first_err_data=din.
- Transitions:
  - RUN -> DRAIN on the cycle rd fires with issued==num_words_q-1.
  - DRAIN -> DONE after the final rd_d1 compare (one cycle). The final compare and counter update land in the same cycle DONE is entered; done asserts the cycle after the last compare.
- Timeout:
  - In RUN, a counter increments each cycle with rd==0 and clears on rd.
  - On reaching TIMEOUT_CYCLES: timeout=1, go to DRAIN if a read is in flight, else DONE. Remaining words are left in the FIFO.
- DONE: holds all status stable; rd=0.
- Widths: exp arithmetic wraps modulo 2^DATA_W (e.g. seed=0xFFFFFFFE, OFFSET=2 gives exp 0x00000000 at index 0).
- Reset mid-run: aborts immediately; state returns to IDLE and no further rd is issued.

Test Plan:
- Clean run: seed=0x10, num_words=4, FIFO preloaded with 0x12,0x13,0x14,0x15 -> 4 consecutive rd cycles; done after last compare; word_count=4, err_count=0, pass=1.
- Single error: same setup with the third word 0xDEAD -> err_count=1, first_err_index=2, first_err_data=0xDEAD, pass=0.
- Gapped input: words arrive with empty toggling every other cycle, num_words=8 -> rd asserted only when !empty; no pop while empty; pass=1.
- Wrap-around: seed=0xFFFFFFFD, num_words=3, data 0xFFFFFFFF,0x00000000,0x00000001 -> pass=1.
- Timeout: num_words=5, only 2 words supplied, TIMEOUT_CYCLES=16 -> timeout=1, word_count=2, done=1, pass=0. num_words=0 with start -> done next cycle, pass=1, rd never asserted.
- Control edge cases: start pulsed during RUN -> ignored, counters unaffected. reset_n dropped mid-run -> outputs 0 asynchronously; a fresh start then succeeds.
